// File: rtl/nice_icb_arbiter.sv
// rtl/nice_icb_arbiter.sv - two-requester ICB arbiter onto the shared NICE memory port
//
// Arbitrates two ICB requesters (m0, m1) onto a single ICB slave port (s).
// Command and response paths are combinational (zero latency). An ID FIFO of
// OUTS_DEPTH entries records which requester issued each accepted command, so
// responses are routed back in issue order.
//
// Optional feature macro: NICE_ARB_RR_EN
//   defined   -> round-robin arbitration on contention
//   undefined -> fixed priority, m0 wins contention
//
// Parameters: OUTS_DEPTH (max outstanding, power of two 2..16), AW, DW
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_icb_cmd_*/m0_icb_rsp_* requester 0 command/response channels
//   m1_icb_cmd_*/m1_icb_rsp_* requester 1 command/response channels
//   s_icb_cmd_*/s_icb_rsp_*   shared memory port
//   mem_holdup               any command pending or outstanding
//   proto_err                sticky: response arrived with nothing outstanding
module nice_icb_arbiter #(
    parameter int OUTS_DEPTH = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic            m0_icb_cmd_read,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic [DW-1:0]   m0_icb_rsp_rdata,
    output logic            m0_icb_rsp_err,
    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic            m1_icb_cmd_read,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic [DW-1:0]   m1_icb_rsp_rdata,
    output logic            m1_icb_rsp_err,
    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic            s_icb_cmd_read,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic [DW-1:0]   s_icb_rsp_rdata,
    input  logic            s_icb_rsp_err,
    output logic            mem_holdup,
    output logic            proto_err
);

    localparam int PW = $clog2(OUTS_DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]         count;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [OUTS_DEPTH-1:0] id_fifo;
    logic                  locked;
    logic                  lock_id;
    logic                  proto_err_q;
    logic                  grant;
    logic                  grant_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_id;
    logic                  push;
    logic                  pop;
    logic                  stray;
    logic                  prio;

`ifdef NICE_ARB_RR_EN
    // prio names the requester that wins the next contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (push) begin
            prio <= ~grant;
        end
    end
`else
    assign prio = 1'b0;
`endif

    assign fifo_full  = (count == CW'(OUTS_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_id    = id_fifo[rptr];

    // A stalled command keeps its grant so the slave sees stable fields.
    always_comb begin
        grant = 1'b0;
        if (locked) begin
            grant = lock_id;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant = prio;
        end else if (m1_icb_cmd_valid) begin
            grant = 1'b1;
        end
    end

    assign grant_valid      = grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    assign s_icb_cmd_valid  = ~rst & grant_valid & ~fifo_full;
    assign m0_icb_cmd_ready = ~rst & s_icb_cmd_ready & ~fifo_full & ~grant;
    assign m1_icb_cmd_ready = ~rst & s_icb_cmd_ready & ~fifo_full & grant;
    assign s_icb_cmd_read   = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_addr   = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_wdata  = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    // With nothing outstanding, responses are accepted and discarded.
    assign s_icb_rsp_ready  = ~rst & (fifo_empty | (head_id ? m1_icb_rsp_ready : m0_icb_rsp_ready));
    assign m0_icb_rsp_valid = ~rst & ~fifo_empty & ~head_id & s_icb_rsp_valid;
    assign m1_icb_rsp_valid = ~rst & ~fifo_empty & head_id & s_icb_rsp_valid;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;

    assign push  = s_icb_cmd_valid & s_icb_cmd_ready;
    assign pop   = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty;
    assign stray = ~rst & s_icb_rsp_valid & fifo_empty;

    assign mem_holdup = m0_icb_cmd_valid | m1_icb_cmd_valid | ~fifo_empty;
    assign proto_err  = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            id_fifo     <= '0;
            locked      <= 1'b0;
            lock_id     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            locked  <= s_icb_cmd_valid & ~s_icb_cmd_ready;
            lock_id <= grant;
            if (push) begin
                id_fifo[wptr] <= grant;
                wptr <= (wptr == PW'(OUTS_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(OUTS_DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (stray) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nice_icb_arbiter.sv
// tb/tb_nice_icb_arbiter.sv - self-checking bench for nice_icb_arbiter
module tb_nice_icb_arbiter;

    localparam int OD = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0] m0_icb_cmd_addr;
    logic [DW-1:0] m0_icb_cmd_wdata;
    logic [3:0]    m0_icb_cmd_wmask;
    logic          m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [DW-1:0] m0_icb_rsp_rdata;
    logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0] m1_icb_cmd_addr;
    logic [DW-1:0] m1_icb_cmd_wdata;
    logic [3:0]    m1_icb_cmd_wmask;
    logic          m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [DW-1:0] m1_icb_rsp_rdata;
    logic          s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0] s_icb_cmd_addr;
    logic [DW-1:0] s_icb_cmd_wdata;
    logic [3:0]    s_icb_cmd_wmask;
    logic          s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [DW-1:0] s_icb_rsp_rdata;
    logic          mem_holdup, proto_err;

    nice_icb_arbiter #(.OUTS_DEPTH(OD), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
        .mem_holdup(mem_holdup), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: outstanding requester IDs in issue order.
    bit  q[$];
    bit  locked_m, lock_m, prio_m, perr_m;
    bit  glog[$];
    bit  rlog[$];
    bit  g, gv, full, empty, head;
    bit  e_scv, e_m0r, e_m1r, e_srr, e_m0rv, e_m1rv, e_hold;
    bit  hs, popm, straym;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            locked_m = 1'b0;
            lock_m   = 1'b0;
            prio_m   = 1'b0;
            perr_m   = 1'b0;
        end
        full  = (q.size() == OD);
        empty = (q.size() == 0);
        head  = empty ? 1'b0 : q[0];
        if (locked_m) g = lock_m;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
`ifdef NICE_ARB_RR_EN
            g = prio_m;
`else
            g = 1'b0;
`endif
        end else g = m1_icb_cmd_valid;
        gv     = g ? m1_icb_cmd_valid : m0_icb_cmd_valid;
        e_scv  = !rst && gv && !full;
        e_m0r  = !rst && s_icb_cmd_ready && !full && !g;
        e_m1r  = !rst && s_icb_cmd_ready && !full && g;
        e_srr  = !rst && (empty || (head ? m1_icb_rsp_ready : m0_icb_rsp_ready));
        e_m0rv = !rst && !empty && !head && s_icb_rsp_valid;
        e_m1rv = !rst && !empty && head && s_icb_rsp_valid;
        e_hold = m0_icb_cmd_valid || m1_icb_cmd_valid || !empty;

        chk("s_cmd_valid", 64'(s_icb_cmd_valid), 64'(e_scv));
        chk("m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'(e_m0r));
        chk("m1_cmd_ready", 64'(m1_icb_cmd_ready), 64'(e_m1r));
        chk("s_rsp_ready", 64'(s_icb_rsp_ready), 64'(e_srr));
        chk("m0_rsp_valid", 64'(m0_icb_rsp_valid), 64'(e_m0rv));
        chk("m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'(e_m1rv));
        chk("mem_holdup", 64'(mem_holdup), 64'(e_hold));
        chk("proto_err", 64'(proto_err), 64'(perr_m));
        if (e_scv) begin
            chk("s_cmd_addr", 64'(s_icb_cmd_addr), 64'(g ? m1_icb_cmd_addr : m0_icb_cmd_addr));
            chk("s_cmd_wdata", 64'(s_icb_cmd_wdata), 64'(g ? m1_icb_cmd_wdata : m0_icb_cmd_wdata));
            chk("s_cmd_rd_mask", 64'({s_icb_cmd_read, s_icb_cmd_wmask}),
                64'(g ? {m1_icb_cmd_read, m1_icb_cmd_wmask} : {m0_icb_cmd_read, m0_icb_cmd_wmask}));
        end
        if (e_m0rv) chk("m0_rsp_data", 64'({m0_icb_rsp_err, m0_icb_rsp_rdata}), 64'({s_icb_rsp_err, s_icb_rsp_rdata}));
        if (e_m1rv) chk("m1_rsp_data", 64'({m1_icb_rsp_err, m1_icb_rsp_rdata}), 64'({s_icb_rsp_err, s_icb_rsp_rdata}));

        if (m0_icb_cmd_valid && m0_icb_cmd_ready) glog.push_back(1'b0);
        if (m1_icb_cmd_valid && m1_icb_cmd_ready) glog.push_back(1'b1);
        if (m0_icb_rsp_valid && m0_icb_rsp_ready) rlog.push_back(1'b0);
        if (m1_icb_rsp_valid && m1_icb_rsp_ready) rlog.push_back(1'b1);

        if (!rst) begin
            hs     = e_scv && s_icb_cmd_ready;
            popm   = !empty && s_icb_rsp_valid && e_srr;
            straym = empty && s_icb_rsp_valid;
            if (popm) void'(q.pop_front());
            if (hs) begin
                q.push_back(g);
                prio_m = !g;
            end
            locked_m = e_scv && !s_icb_cmd_ready;
            lock_m   = g;
            if (straym) perr_m = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = '0;
        m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = '0;
        m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 0;
        s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = '0; s_icb_rsp_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drain(input int n);
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        for (int k = 0; k < n; k++) begin
            s_icb_rsp_rdata = 32'h5000 + 32'(k);
            step();
        end
        s_icb_rsp_valid = 0;
    endtask

    bit exp_g[4];
    bit exp_r[5];

    initial begin
        rst = 1'b1;
        idle();
        step();
        #1;
        chk("reset_holdup", 64'(mem_holdup), 64'd0);
        chk("reset_srr", 64'(s_icb_rsp_ready), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Single read from m0, response next cycle.
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 32'h100; s_icb_cmd_ready = 1;
        #1 chk("rd_cmd_ready", 64'(m0_icb_cmd_ready), 64'd1);
        chk("rd_cmd_addr", 64'(s_icb_cmd_addr), 64'h100);
        step();
        m0_icb_cmd_valid = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hDEADBEEF; m0_icb_rsp_ready = 1;
        #1 chk("rd_rsp_valid", 64'(m0_icb_rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(m0_icb_rsp_rdata), 64'hDEADBEEF);
        chk("rd_m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'd0);
        step();
        s_icb_rsp_valid = 0;
        #1 chk("rd_count_zero", 64'(mem_holdup), 64'd0);

        // Continuous contention for four cycles.
        do_reset();
        glog.delete();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h10;
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h20; s_icb_cmd_ready = 1;
        repeat (4) step();
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
`ifdef NICE_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        chk("contend_n", 64'(glog.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < glog.size()) chk($sformatf("contend_grant%0d", k), 64'(glog[k]), 64'(exp_g[k]));
        drain(4);

        // m1 stalled for three cycles keeps the grant against m0.
        do_reset();
        glog.delete();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200; s_icb_cmd_ready = 0;
        step();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h300;
        #1 chk("lock_addr1", 64'(s_icb_cmd_addr), 64'h200);
        step();
        chk("lock_addr2", 64'(s_icb_cmd_addr), 64'h200);
        step();
        s_icb_cmd_ready = 1;
        #1 chk("lock_m1_ready", 64'(m1_icb_cmd_ready), 64'd1);
        chk("lock_m0_ready", 64'(m0_icb_cmd_ready), 64'd0);
        step();
        m1_icb_cmd_valid = 0;
        step();
        m0_icb_cmd_valid = 0;
        chk("lock_order_n", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) chk("lock_order", 64'({glog[0], glog[1]}), 64'b10);
        drain(2);

        // Fill the ID FIFO, then check full blocking and in-order routing.
        do_reset();
        rlog.delete();
        s_icb_cmd_ready = 1;
        exp_g = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            m0_icb_cmd_valid = !exp_g[k]; m1_icb_cmd_valid = exp_g[k];
            m0_icb_cmd_wdata = 32'(k); m1_icb_cmd_wdata = 32'(k + 8);
            step();
        end
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 0;
        #1 chk("full_ready", 64'(m0_icb_cmd_ready), 64'd0);
        chk("full_s_valid", 64'(s_icb_cmd_valid), 64'd0);
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1; s_icb_rsp_rdata = 32'hA0;
        #1 chk("full_pop_ready", 64'(m0_icb_cmd_ready), 64'd0);
        chk("full_head_rsp", 64'(m0_icb_rsp_valid), 64'd1);
        step();
        s_icb_rsp_valid = 0;
        #1 chk("after_pop_ready", 64'(m0_icb_cmd_ready), 64'd1);
        step();
        m0_icb_cmd_valid = 0;
        drain(4);
        exp_r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        chk("rsp_order_n", 64'(rlog.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            if (k < rlog.size()) chk($sformatf("rsp_order%0d", k), 64'(rlog[k]), 64'(exp_r[k]));

        // Stray response with nothing outstanding.
        do_reset();
        s_icb_rsp_valid = 1;
        #1 chk("stray_srr", 64'(s_icb_rsp_ready), 64'd1);
        chk("stray_m0rv", 64'(m0_icb_rsp_valid), 64'd0);
        chk("stray_m1rv", 64'(m1_icb_rsp_valid), 64'd0);
        chk("stray_perr0", 64'(proto_err), 64'd0);
        step();
        s_icb_rsp_valid = 0;
        #1 chk("stray_perr1", 64'(proto_err), 64'd1);
        repeat (3) step();
        chk("stray_perr_held", 64'(proto_err), 64'd1);

        // Reset with two commands outstanding.
        m0_icb_cmd_valid = 1; s_icb_cmd_ready = 1;
        step();
        step();
        m0_icb_cmd_valid = 0;
        #1 chk("pre_rst_holdup", 64'(mem_holdup), 64'd1);
        rst = 1;
        #1 chk("rst_holdup", 64'(mem_holdup), 64'd0);
        chk("rst_perr", 64'(proto_err), 64'd0);
        chk("rst_s_valid", 64'(s_icb_cmd_valid), 64'd0);
        step();
        rst = 0;
        step();
        s_icb_rsp_valid = 1;
        step();
        s_icb_rsp_valid = 0;
        #1 chk("post_rst_stray", 64'(proto_err), 64'd1);

        // Directed pattern mix checked by the model every cycle.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            m0_icb_cmd_valid = (i % 3) != 0;
            m1_icb_cmd_valid = (i % 2) == 1;
            m0_icb_cmd_addr  = 32'h1000 + 32'(i);
            m1_icb_cmd_addr  = 32'h2000 + 32'(i);
            m0_icb_cmd_read  = i[0];
            m1_icb_cmd_wmask = 4'(i);
            s_icb_cmd_ready  = (i % 5) != 1;
            s_icb_rsp_valid  = (i % 4) != 0;
            s_icb_rsp_err    = (i % 7) == 3;
            s_icb_rsp_rdata  = 32'(i) * 32'h01010101;
            m0_icb_rsp_ready = (i % 6) != 2;
            m1_icb_rsp_ready = (i % 3) != 1;
            step();
        end
        idle();
        s_icb_cmd_ready = 1;
        drain(6);
        #1 chk("final_holdup", 64'(mem_holdup), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nice_icb_arbiter.md
NICE_ICB_ARBITER -- requirements
Module: nice_icb_arbiter

Interface
REQ-001 SHALL have parameter OUTS_DEPTH, default 4: max outstanding ICB commands (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; wmask width DW/8.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports m0_icb_cmd_valid/read in 1, m0_icb_cmd_addr in AW, m0_icb_cmd_wdata in DW, m0_icb_cmd_wmask in DW/8, m0_icb_cmd_ready out 1: requester 0 command channel.
REQ-007 SHALL have ports m0_icb_rsp_valid out 1, m0_icb_rsp_rdata out DW, m0_icb_rsp_err out 1, m0_icb_rsp_ready in 1: requester 0 response channel.
REQ-008 SHALL have ports m1_icb_*, identical to REQ-006/007: requester 1 channels.
REQ-009 SHALL have ports s_icb_cmd_valid/addr/read/wdata/wmask out, s_icb_cmd_ready in, s_icb_rsp_valid/rdata/err in, s_icb_rsp_ready out: shared NICE memory port.
REQ-010 SHALL have port mem_holdup  out  1: NICE memory-holdup to core.
REQ-011 SHALL have port proto_err  out  1: sticky unexpected-response flag.

Function
REQ-012 Grant: only m0 valid -> m0; only m1 valid -> m1; both valid -> per REQ-030/031.
REQ-013 Granted requester's cmd fields SHALL pass combinationally to s_icb_cmd_*; s_icb_cmd_valid = granted valid AND NOT fifo_full.
REQ-014 Granted mN_icb_cmd_ready = s_icb_cmd_ready AND NOT fifo_full; non-granted ready = 0.
REQ-015 Lock: s_icb_cmd_valid=1 with s_icb_cmd_ready=0 SHALL freeze the grant until that command handshakes, regardless of the other requester.
REQ-016 On each s_icb_cmd handshake, granted ID SHALL be pushed into an OUTS_DEPTH-entry ID FIFO.
REQ-017 fifo_full (count==OUTS_DEPTH) SHALL block new commands even if a pop occurs the same cycle.
REQ-018 s_icb_rsp_* SHALL route to requester at FIFO head; s_icb_rsp_ready = that requester's rsp_ready; other requester rsp_valid = 0.
REQ-019 On s_icb_rsp handshake, FIFO SHALL pop; simultaneous push+pop leaves count unchanged.
REQ-020 Response arrival with FIFO empty: s_icb_rsp_ready = 1, response dropped, proto_err set next cycle, held until reset.
REQ-021 Count width clog2(OUTS_DEPTH)+1; read/write pointers wrap modulo OUTS_DEPTH.
REQ-022 mem_holdup = m0 cmd valid OR m1 cmd valid OR count != 0 (combinational).
REQ-023 Zero-cycle latency cmd and rsp paths; no added bubbles when FIFO not full.

Reset
REQ-024 rst SHALL asynchronously clear FIFO count and pointers, lock, priority pointer (to m0), proto_err.
REQ-025 During reset all ready/valid outputs SHALL be 0; mem_holdup follows REQ-022 with count=0.
REQ-026 Reset mid-transaction SHALL discard outstanding IDs; later stray responses handled per REQ-020.

Configuration
REQ-030 With NICE_ARB_RR_EN defined: round-robin; priority pointer toggles to the non-winner after every accepted command.
REQ-031 Without NICE_ARB_RR_EN: fixed priority, m0 always wins contention; no priority pointer register.

Verification
REQ-040 m0 read addr 0x100, s_icb_cmd_ready=1, rsp rdata 0xDEADBEEF next cycle -> m0_icb_rsp_rdata=0xDEADBEEF, m1 rsp_valid=0, count returns 0.
REQ-041 Both valid continuously, ready=1, 4 cycles, RR_EN defined -> grant order m0,m1,m0,m1; undefined -> m0 x4.
REQ-042 m1 cmd stalled 3 cycles (ready=0) while m0 asserts valid -> grant stays m1 until handshake.
REQ-043 OUTS_DEPTH=4, 4 commands accepted, no responses -> 5th cmd_ready=0; one response -> next cycle ready=1; responses return in issue-ID order.
REQ-044 s_icb_rsp_valid with count=0 -> rsp_ready=1, no mN rsp_valid, proto_err=1 next cycle, held.
REQ-045 Assert rst with 2 outstanding -> count=0, mem_holdup=0 immediately with no cmd valid, proto_err=0.
